// File: rtl/map_loader.sv
// Level loader: copies ROWS level-ROM words into the map RAM, counting dots and pills on the way,
// then tracks remaining dots/pills from collision pulses to flag a cleared level.
module map_loader #(
    parameter int unsigned ROWS = 20,
    parameter int unsigned COLS = 40
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    output logic [4:0]          rom_addr,
    input  logic [4*COLS-1:0]   rom_q,
    output logic [4:0]          ram_addr,
    output logic [4*COLS-1:0]   ram_data,
    output logic                ram_wren,
    output logic                busy,
    output logic                done,
    input  logic                dot_eaten,
    input  logic                pill_eaten,
    output logic [10:0]         dots_left,
    output logic [7:0]          pills_left,
    output logic                level_clear
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StDone
    } state_e;

    localparam logic [4:0] LastRow = 5'(ROWS - 1);

    state_e      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [10:0] dots_q, dots_d;
    logic [7:0]  pills_q, pills_d;
    logic        loaded_q, loaded_d;

    logic [5:0]  row_dots;
    logic [5:0]  row_pills;
    logic [3:0]  nib;

    // Column 0 sits in the most significant nibble.
    always_comb begin
        row_dots  = '0;
        row_pills = '0;
        nib       = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            nib = rom_q[4*COLS-1-4*c -: 4];
            if (nib == 4'd2) row_dots = row_dots + 6'd1;
            if (nib == 4'd3) row_pills = row_pills + 6'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        dots_d   = dots_q;
        pills_d  = pills_q;
        loaded_d = loaded_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StFetch;
                    row_d    = '0;
                    dots_d   = '0;
                    pills_d  = '0;
                    loaded_d = 1'b0;
                end else begin
                    if (dot_eaten && dots_q != '0) dots_d = dots_q - 11'd1;
                    if (pill_eaten && pills_q != '0) pills_d = pills_q - 8'd1;
                end
            end
            StFetch: begin
                state_d = StWrite;
            end
            StWrite: begin
                dots_d  = dots_q + {5'd0, row_dots};
                pills_d = pills_q + {2'd0, row_pills};
                if (row_q == LastRow) begin
                    state_d = StDone;
                end else begin
                    row_d   = row_q + 5'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                loaded_d = 1'b1;
                state_d  = StIdle;
                // Not busy here, so collision pulses already count.
                if (dot_eaten && dots_q != '0) dots_d = dots_q - 11'd1;
                if (pill_eaten && pills_q != '0) pills_d = pills_q - 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            row_q    <= '0;
            dots_q   <= '0;
            pills_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            dots_q   <= dots_d;
            pills_q  <= pills_d;
            loaded_q <= loaded_d;
        end
    end

    assign rom_addr    = row_q;
    assign ram_addr    = row_q;
    assign ram_data    = rom_q;
    assign ram_wren    = (state_q == StWrite);
    assign busy        = (state_q == StFetch) || (state_q == StWrite);
    assign done        = (state_q == StDone);
    assign dots_left   = dots_q;
    assign pills_left  = pills_q;
    assign level_clear = loaded_q && (dots_q == '0) && (pills_q == '0) && !busy;

endmodule
